// File: rtl/cp0_exc_ctrl_pkg.sv
// Shared constants for the CP0 exception controller: ExcCodes, CP0 register
// addresses, MEM exception flag bit positions and the default handler vector.
package cp0_exc_ctrl_pkg;

  localparam logic [4:0] EXC_CODE_INT  = 5'h00;
  localparam logic [4:0] EXC_CODE_ADEL = 5'h04;
  localparam logic [4:0] EXC_CODE_SYS  = 5'h08;
  localparam logic [4:0] EXC_CODE_BP   = 5'h09;
  localparam logic [4:0] EXC_CODE_RI   = 5'h0A;
  localparam logic [4:0] EXC_CODE_OV   = 5'h0C;
  localparam logic [4:0] EXC_CODE_ERET = 5'h0E;

  localparam logic [4:0] CP0_ADDR_STATUS = 5'd12;
  localparam logic [4:0] CP0_ADDR_CAUSE  = 5'd13;
  localparam logic [4:0] CP0_ADDR_EPC    = 5'd14;

  localparam int EXC_BIT_ADEL = 5;
  localparam int EXC_BIT_RI   = 4;
  localparam int EXC_BIT_OV   = 3;
  localparam int EXC_BIT_SYS  = 2;
  localparam int EXC_BIT_BP   = 1;
  localparam int EXC_BIT_ERET = 0;

  localparam logic [31:0] EXC_VECTOR_DEF = 32'h0000_0020;
  localparam int          CNT_W          = 3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } exc_state_t;

  // An mtc0 in WB lands in CP0 only at the end of this cycle, so bypass it.
  function automatic logic [31:0] fwd_reg(input logic        we,
                                          input logic [4:0]  waddr,
                                          input logic [4:0]  addr,
                                          input logic [31:0] wdata,
                                          input logic [31:0] cur);
    return (we && (waddr == addr)) ? wdata : cur;
  endfunction

endpackage

// File: rtl/exc_int_sync.sv
// Two-flop synchroniser for asynchronous level inputs, one chain per bit.
module exc_int_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/cp0_exc_ctrl.sv
// Exception/interrupt arbiter between MEM and CP0: picks the top-priority event,
// pulses the CP0 update strobe and holds pipeline flush for a fixed window.
//
// state    | meaning
// ST_IDLE  | watching MEM for interrupts and exception flags
// ST_FLUSH | flush window running, MEM flags ignored until counter hits 0
module cp0_exc_ctrl
  import cp0_exc_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR   = EXC_VECTOR_DEF,
  parameter int unsigned FLUSH_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  int_i,
  input  logic        timer_int_i,
  input  logic        mem_valid_i,
  input  logic [31:0] mem_pc_i,
  input  logic        mem_in_delayslot_i,
  input  logic [5:0]  mem_exc_i,
  input  logic [31:0] cp0_status_i,
  input  logic [31:0] cp0_cause_i,
  input  logic [31:0] cp0_epc_i,
  input  logic        wb_cp0_we_i,
  input  logic [4:0]  wb_cp0_waddr_i,
  input  logic [31:0] wb_cp0_wdata_i,
  output logic        flush_o,
  output logic [31:0] new_pc_o,
  output logic        exc_we_o,
  output logic [4:0]  exc_code_o,
  output logic [31:0] exc_epc_o,
  output logic        exc_bd_o,
  output logic        eret_o
);

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(FLUSH_CYCLES - 1);

  logic [5:0]  int_sync;
  logic [5:0]  hw_ip;
  logic [7:0]  ip;
  logic [31:0] status_eff, cause_eff, epc_eff;
  logic [5:0]  flags;
  logic        int_pend;
  logic        evt;
  logic        evt_eret;
  logic [4:0]  evt_code;
  logic        unused_bits;

  exc_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             flush_d, we_d, bd_d, eret_d;
  logic [31:0]      new_pc_d, epc_d;
  logic [4:0]       code_d;

  exc_int_sync #(.WIDTH(6)) u_int_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (int_i),
    .q     (int_sync)
  );

  assign hw_ip      = int_sync | {timer_int_i, 5'b0};
  assign status_eff = fwd_reg(wb_cp0_we_i, wb_cp0_waddr_i, CP0_ADDR_STATUS, wb_cp0_wdata_i, cp0_status_i);
  assign cause_eff  = fwd_reg(wb_cp0_we_i, wb_cp0_waddr_i, CP0_ADDR_CAUSE, wb_cp0_wdata_i, cp0_cause_i);
  assign epc_eff    = fwd_reg(wb_cp0_we_i, wb_cp0_waddr_i, CP0_ADDR_EPC, wb_cp0_wdata_i, cp0_epc_i);
  assign ip         = {hw_ip, cause_eff[9:8]};
  assign flags      = mem_valid_i ? mem_exc_i : 6'b0;
  assign int_pend   = mem_valid_i && status_eff[0] && !status_eff[1] && ((ip & status_eff[15:8]) != 8'h00);

  assign unused_bits = ^{status_eff[31:16], status_eff[7:2], cause_eff[31:10], cause_eff[7:0]};

  always_comb begin
    evt      = 1'b1;
    evt_eret = 1'b0;
    evt_code = EXC_CODE_INT;
    if (int_pend)                  evt_code = EXC_CODE_INT;
    else if (flags[EXC_BIT_ADEL])  evt_code = EXC_CODE_ADEL;
    else if (flags[EXC_BIT_RI])    evt_code = EXC_CODE_RI;
    else if (flags[EXC_BIT_OV])    evt_code = EXC_CODE_OV;
    else if (flags[EXC_BIT_SYS])   evt_code = EXC_CODE_SYS;
    else if (flags[EXC_BIT_BP])    evt_code = EXC_CODE_BP;
    else if (flags[EXC_BIT_ERET]) begin
      evt_code = EXC_CODE_ERET;
      evt_eret = 1'b1;
    end else begin
      evt = 1'b0;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    flush_d  = flush_o;
    we_d     = 1'b0;
    eret_d   = 1'b0;
    new_pc_d = new_pc_o;
    code_d   = exc_code_o;
    epc_d    = exc_epc_o;
    bd_d     = exc_bd_o;
    case (state_q)
      ST_IDLE: begin
        flush_d = 1'b0;
        if (evt) begin
          flush_d = 1'b1;
          we_d    = 1'b1;
          code_d  = evt_code;
          if (evt_eret) begin
            new_pc_d = epc_eff;
            eret_d   = 1'b1;
          end else begin
            new_pc_d = EXC_VECTOR;
            epc_d    = mem_in_delayslot_i ? (mem_pc_i - 32'd4) : mem_pc_i;
            bd_d     = mem_in_delayslot_i;
          end
          // A one-cycle window needs no dwell: IDLE drops flush next cycle.
          if (FLUSH_CYCLES > 1) begin
            state_d = ST_FLUSH;
            cnt_d   = CNT_INIT;
          end
        end
      end
      ST_FLUSH: begin
        if (cnt_q == '0) begin
          flush_d = 1'b0;
          state_d = ST_IDLE;
        end else begin
          flush_d = 1'b1;
          cnt_d   = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        flush_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      flush_o    <= 1'b0;
      new_pc_o   <= '0;
      exc_we_o   <= 1'b0;
      exc_code_o <= '0;
      exc_epc_o  <= '0;
      exc_bd_o   <= 1'b0;
      eret_o     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      flush_o    <= flush_d;
      new_pc_o   <= new_pc_d;
      exc_we_o   <= we_d;
      exc_code_o <= code_d;
      exc_epc_o  <= epc_d;
      exc_bd_o   <= bd_d;
      eret_o     <= eret_d;
    end
  end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Self-checking bench for cp0_exc_ctrl: directed scenarios plus randomized
// events checked against a rule-level reference model.
module tb_cp0_exc_ctrl;

  localparam int FLUSH_N = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  int_i;
  logic        timer_int;
  logic        mem_valid;
  logic [31:0] mem_pc;
  logic        mem_ds;
  logic [5:0]  mem_exc;
  logic [31:0] cp0_status, cp0_cause, cp0_epc;
  logic        wb_we;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
  logic        flush_o, exc_we_o, exc_bd_o, eret_o;
  logic [31:0] new_pc_o, exc_epc_o;
  logic [4:0]  exc_code_o;

  int checks   = 0;
  int failures = 0;
  logic [31:0] m_epc;
  logic        m_bd;

  logic [72:0] obs;
  assign obs = {flush_o, exc_we_o, exc_code_o, new_pc_o, exc_epc_o, exc_bd_o, eret_o};

  typedef struct packed {
    logic        hit;
    logic [4:0]  code;
    logic [31:0] new_pc;
    logic [31:0] epc;
    logic        bd;
    logic        eret;
  } exp_t;

  cp0_exc_ctrl dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .int_i              (int_i),
    .timer_int_i        (timer_int),
    .mem_valid_i        (mem_valid),
    .mem_pc_i           (mem_pc),
    .mem_in_delayslot_i (mem_ds),
    .mem_exc_i          (mem_exc),
    .cp0_status_i       (cp0_status),
    .cp0_cause_i        (cp0_cause),
    .cp0_epc_i          (cp0_epc),
    .wb_cp0_we_i        (wb_we),
    .wb_cp0_waddr_i     (wb_waddr),
    .wb_cp0_wdata_i     (wb_wdata),
    .flush_o            (flush_o),
    .new_pc_o           (new_pc_o),
    .exc_we_o           (exc_we_o),
    .exc_code_o         (exc_code_o),
    .exc_epc_o          (exc_epc_o),
    .exc_bd_o           (exc_bd_o),
    .eret_o             (eret_o)
  );

  always #5 clk = ~clk;

  // Reference: what the arbiter should report for the stimulus currently driven,
  // given the settled (synchronised) level of the interrupt lines.
  function automatic exp_t predict(input logic [5:0] lines);
    exp_t e;
    logic [31:0] st, ca, ep;
    logic [7:0]  ip;
    logic [4:0]  code_of_bit [0:5];
    logic        found;
    code_of_bit[5] = 5'h04; code_of_bit[4] = 5'h0A; code_of_bit[3] = 5'h0C;
    code_of_bit[2] = 5'h08; code_of_bit[1] = 5'h09; code_of_bit[0] = 5'h0E;
    st = (wb_we && wb_waddr == 5'd12) ? wb_wdata : cp0_status;
    ca = (wb_we && wb_waddr == 5'd13) ? wb_wdata : cp0_cause;
    ep = (wb_we && wb_waddr == 5'd14) ? wb_wdata : cp0_epc;
    ip = {lines | {timer_int, 5'b0}, ca[9:8]};
    e = '{hit: 1'b0, code: 5'h0, new_pc: 32'h20, epc: m_epc, bd: m_bd, eret: 1'b0};
    found = 1'b0;
    if (mem_valid) begin
      if (st[0] && !st[1] && (ip & st[15:8]) != 8'h00) begin
        found = 1'b1;
        e.code = 5'h00;
      end
      for (int b = 5; b >= 0; b--) begin
        if (!found && mem_exc[b]) begin
          found = 1'b1;
          e.code = code_of_bit[b];
        end
      end
    end
    e.hit = found;
    if (found && e.code == 5'h0E) begin
      e.eret = 1'b1;
      e.new_pc = ep;
    end else if (found) begin
      e.epc = mem_ds ? mem_pc - 32'd4 : mem_pc;
      e.bd  = mem_ds;
    end
    return e;
  endfunction

  task automatic clear_inputs();
    int_i = '0; timer_int = 1'b0; mem_valid = 1'b0; mem_pc = '0; mem_ds = 1'b0;
    mem_exc = '0; cp0_status = '0; cp0_cause = '0; cp0_epc = '0;
    wb_we = 1'b0; wb_waddr = '0; wb_wdata = '0;
  endtask

  // Drive one MEM instruction for one cycle and leave the bench just after the
  // registering edge, with the instruction withdrawn.
  task automatic issue(input logic [31:0] pc, input logic ds, input logic [5:0] fl,
                       output exp_t e);
    @(negedge clk);
    mem_valid = 1'b1; mem_pc = pc; mem_ds = ds; mem_exc = fl;
    e = predict(int_i);
    @(posedge clk); #1;
    mem_valid = 1'b0; mem_exc = '0; wb_we = 1'b0;
  endtask

  // Count cycles flush_o stays high, starting from the current sample.
  task automatic measure_flush(output int n);
    n = 0;
    if (flush_o) n = 1;
    for (int i = 0; i < 20 && flush_o; i++) begin
      @(posedge clk); #1;
      if (flush_o) n++;
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (obs !== '0) begin failures++; $display("FAIL reset_outputs got=%h exp=0", obs); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (obs !== '0) begin failures++; $display("FAIL post_reset_idle got=%h exp=0", obs); end
    m_epc = '0; m_bd = 1'b0;
  endtask

  task automatic test_sys();
    exp_t e; int n;
    issue(32'h100, 1'b0, 6'b000100, e);
    checks++;
    if (obs !== {2'b11, 5'h08, 32'h20, 32'h100, 1'b0, 1'b0}) begin
      failures++; $display("FAIL sys_event got=%h exp=%h", obs, {2'b11, 5'h08, 32'h20, 32'h100, 2'b00});
    end
    m_epc = 32'h100; m_bd = 1'b0;
    measure_flush(n);
    checks++;
    if (n !== FLUSH_N) begin failures++; $display("FAIL sys_flush_len got=%0d exp=%0d", n, FLUSH_N); end
  endtask

  task automatic test_delay_slot();
    exp_t e; int n;
    issue(32'h204, 1'b1, 6'b001000, e);
    checks++;
    if (obs !== {2'b11, 5'h0C, 32'h20, 32'h200, 1'b1, 1'b0}) begin
      failures++; $display("FAIL ov_delay_slot got=%h", obs);
    end
    measure_flush(n);
    issue(32'h0, 1'b1, 6'b001000, e);
    checks++;
    if (obs !== {2'b11, 5'h0C, 32'h20, 32'hFFFF_FFFC, 1'b1, 1'b0}) begin
      failures++; $display("FAIL pc_wrap got=%h exp_epc=fffffffc", obs);
    end
    m_epc = 32'hFFFF_FFFC; m_bd = 1'b1;
    measure_flush(n);
  endtask

  task automatic test_interrupt();
    int n, strobes;
    @(negedge clk);
    cp0_status = 32'h0000_0401; int_i = 6'b000001;
    mem_valid = 1'b1; mem_pc = 32'h300; mem_ds = 1'b0; mem_exc = '0;
    strobes = 0;
    repeat (2) begin
      @(posedge clk); #1;
      if (exc_we_o) strobes++;
    end
    checks++;
    if (strobes !== 0) begin failures++; $display("FAIL int_sync_latency got=%0d strobes exp=0", strobes); end
    @(posedge clk); #1;
    mem_valid = 1'b0;
    checks++;
    if (obs !== {2'b11, 5'h00, 32'h20, 32'h300, 1'b0, 1'b0}) begin
      failures++; $display("FAIL int_taken got=%h", obs);
    end
    m_epc = 32'h300; m_bd = 1'b0;
    measure_flush(n);
    @(negedge clk);
    cp0_status = 32'h0000_0403; mem_valid = 1'b1;
    strobes = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (exc_we_o || flush_o) strobes++;
    end
    checks++;
    if (strobes !== 0) begin failures++; $display("FAIL int_exl_blocked got=%0d events exp=0", strobes); end
    @(negedge clk);
    cp0_status = 32'h0000_0401;
    @(posedge clk); #1;
    mem_valid = 1'b0;
    checks++;
    if (obs !== {2'b11, 5'h00, 32'h20, 32'h300, 1'b0, 1'b0}) begin
      failures++; $display("FAIL int_pending_after_exl got=%h", obs);
    end
    measure_flush(n);
    @(negedge clk); int_i = '0; cp0_status = '0;
    repeat (3) @(posedge clk);
  endtask

  task automatic test_eret_forward();
    exp_t e; int n;
    @(negedge clk);
    cp0_epc = 32'hDEAD_BEEF; wb_we = 1'b1; wb_waddr = 5'd14; wb_wdata = 32'h1234;
    issue(32'h500, 1'b1, 6'b000001, e);
    checks++;
    if (obs !== {2'b11, 5'h0E, 32'h1234, m_epc, m_bd, 1'b1}) begin
      failures++; $display("FAIL eret_forward got=%h exp=%h", obs, {2'b11, 5'h0E, 32'h1234, m_epc, m_bd, 1'b1});
    end
    measure_flush(n);
    checks++;
    if (n !== FLUSH_N) begin failures++; $display("FAIL eret_flush_len got=%0d exp=%0d", n, FLUSH_N); end
    cp0_epc = '0;
  endtask

  task automatic test_back_to_back();
    exp_t e; int n;
    issue(32'h600, 1'b0, 6'b010010, e);
    checks++;
    if (obs !== {2'b11, 5'h0A, 32'h20, 32'h600, 1'b0, 1'b0}) begin
      failures++; $display("FAIL ri_bp_priority got=%h", obs);
    end
    m_epc = 32'h600; m_bd = 1'b0;
    mem_valid = 1'b1; mem_pc = 32'h700; mem_exc = 6'b000100;
    repeat (2) begin
      @(posedge clk); #1;
      checks++;
      if ({flush_o, exc_we_o} !== 2'b10) begin
        failures++; $display("FAIL sys_in_flush got=%b exp=10", {flush_o, exc_we_o});
      end
    end
    mem_valid = 1'b0; mem_exc = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if ({flush_o, exc_we_o} !== 2'b00) begin
      failures++; $display("FAIL flush_end got=%b exp=00", {flush_o, exc_we_o});
    end
  endtask

  task automatic test_reset_mid_flush();
    exp_t e; int n;
    issue(32'h800, 1'b0, 6'b000100, e);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== '0) begin failures++; $display("FAIL reset_mid_flush got=%h exp=0", obs); end
    @(negedge clk); rst_n = 1'b1;
    m_epc = '0; m_bd = 1'b0;
    issue(32'h900, 1'b0, 6'b000100, e);
    checks++;
    if (obs !== {2'b11, 5'h08, 32'h20, 32'h900, 1'b0, 1'b0}) begin
      failures++; $display("FAIL sys_after_reset got=%h", obs);
    end
    m_epc = 32'h900;
    measure_flush(n);
    checks++;
    if (n !== FLUSH_N) begin failures++; $display("FAIL after_reset_flush_len got=%0d exp=%0d", n, FLUSH_N); end
  endtask

  task automatic test_random(input int iters);
    exp_t e; int n;
    logic [4:0] addr_pick [0:3];
    for (int it = 0; it < iters; it++) begin
      @(negedge clk);
      int_i = ($urandom_range(0, 1) == 0) ? 6'b0 : 6'($urandom);
      repeat (3) @(posedge clk);
      @(negedge clk);
      addr_pick[0] = 5'd12; addr_pick[1] = 5'd13; addr_pick[2] = 5'd14;
      addr_pick[3] = 5'($urandom);
      cp0_status = $urandom; cp0_cause = $urandom; cp0_epc = $urandom;
      timer_int  = 1'($urandom);
      wb_we      = 1'($urandom);
      wb_waddr   = addr_pick[$urandom_range(0, 3)];
      wb_wdata   = $urandom;
      mem_valid  = ($urandom_range(0, 3) != 0);
      mem_pc     = $urandom;
      mem_ds     = 1'($urandom);
      mem_exc    = 6'($urandom) & 6'($urandom);
      e = predict(int_i);
      @(posedge clk); #1;
      mem_valid = 1'b0; mem_exc = '0; wb_we = 1'b0; timer_int = 1'b0;
      checks++;
      if (e.hit) begin
        if (obs !== {2'b11, e.code, e.new_pc, e.epc, e.bd, e.eret}) begin
          failures++; $display("FAIL rand_event it=%0d got=%h exp=%h", it, obs, {2'b11, e.code, e.new_pc, e.epc, e.bd, e.eret});
        end
        m_epc = e.epc; m_bd = e.bd;
        measure_flush(n);
        checks++;
        if (n !== FLUSH_N) begin failures++; $display("FAIL rand_flush_len it=%0d got=%0d exp=%0d", it, n, FLUSH_N); end
      end else if ({flush_o, exc_we_o} !== 2'b00) begin
        failures++; $display("FAIL rand_no_event it=%0d got=%b exp=00", it, {flush_o, exc_we_o});
      end
    end
    int_i = '0;
    cp0_status = '0;
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #10;
    test_reset();
    test_sys();
    test_delay_slot();
    test_interrupt();
    test_eret_forward();
    test_back_to_back();
    test_reset_mid_flush();
    test_random(80);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cp0_exc_ctrl.md
Name: cp0_exc_ctrl

Overview:
- Exception/interrupt arbiter between the MEM stage and the CP0 register block.
- Takes per-instruction exception flags from MEM, the CP0 Status/Cause/EPC values and the external interrupt lines.
- Selects the highest-priority event and drives pipeline flush and redirect PC.
- Emits a one-cycle CP0 exception-update strobe carrying ExcCode, EPC, BD and EXL set/clear.
- Holds flush for a fixed window so in-flight instructions cannot raise a second exception.

Parameters:
- EXC_VECTOR, 32'h0000_0020, handler entry PC for all exceptions and interrupts.
- FLUSH_CYCLES, 3, number of cycles flush_o stays asserted per event (range 1..7).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset: one clock; reset is asynchronous and active-low.
- int_i  in  6  raw hardware interrupt lines (asynchronous).
- timer_int_i  in  1  CP0 timer interrupt, ORed into line 5.
- mem_valid_i  in  1  MEM holds a real instruction, not a bubble.
- mem_pc_i  in  32  PC of the MEM instruction.
- mem_in_delayslot_i  in  1  MEM instruction sits in a branch delay slot.
- mem_exc_i  in  6  flags {adel_if, ri, ov, sys, bp, eret}, bit5..bit0.
- cp0_status_i, cp0_cause_i, cp0_epc_i  in  32 each  current CP0 register values.
- wb_cp0_we_i  in  1  mtc0 in WB this cycle.
- wb_cp0_waddr_i  in  5  its target register.
- wb_cp0_wdata_i  in  32  its data.
- flush_o  out  1  flush IF..MEM.
- new_pc_o  out  32  redirect target, valid while flush_o=1.
- exc_we_o  out  1  one-cycle CP0 update strobe.
- exc_code_o  out  5  Cause.ExcCode value.
- exc_epc_o  out  32  EPC value to write.
- exc_bd_o  out  1  Cause.BD value.
- eret_o  out  1  with exc_we_o: clear Status.EXL instead of setting it.

Behaviour:
- Reset (async, rst_n=0): all outputs 0, FSM=IDLE, flush counter 0, synchroniser flops 0.
- Interrupt synchroniser:
  - 2-flop sync per bit of int_i.
  - hw_ip[5:0] = sync(int_i) | {timer_int_i,5'b0}.
- Forwarding: effective Status/Cause/EPC = wb_cp0_wdata_i when wb_cp0_we_i=1 and waddr matches (12/13/14); otherwise the cp0_*_i value.
- Effective Cause IP = {hw_ip, Cause[9:8]}.
- Interrupt pending when all hold: Status[0]=1, Status[1]=0, (IP & Status[15:8]) != 0, mem_valid_i=1.
- Priority, high to low:
  - interrupt, code 0x00
  - adel_if, 0x04
  - ri, 0x0A
  - ov, 0x0C
  - sys, 0x08
  - bp, 0x09
  - eret, 0x0E (internal).
- Flags are ignored when mem_valid_i=0.
- FSM states: IDLE, FLUSH.
- IDLE: event detected in cycle N, registered in N+1:
  - flush_o=1 and exc_we_o=1 for exactly one cycle.
  - exc_code_o = code.
  - Non-eret event: new_pc_o = EXC_VECTOR; eret_o=0; if delay slot then exc_epc_o = mem_pc_i-4 and exc_bd_o=1, else exc_epc_o = mem_pc_i and exc_bd_o=0.
  - eret event: new_pc_o = effective EPC; eret_o=1; exc_epc_o and exc_bd_o hold.
  - Transition to FLUSH with counter = FLUSH_CYCLES-1.
- FLUSH:
  - flush_o=1, exc_we_o=0, all MEM flags ignored.
  - Counter decrements each cycle; at 0, flush_o drops the next cycle and FSM returns to IDLE.
  - FLUSH_CYCLES=1 means no FLUSH dwell.
- Simultaneous events: only the highest-priority one is taken; the others are lost (the pipeline flushes them).
- Interrupt with EXL=1: not taken; the synchronised level stays pending until EXL clears.
- Arithmetic: PC-4 is modulo 2^32 (0x0000_0000 gives 0xFFFF_FFFC).
- Reset mid-FLUSH: immediate return to IDLE with outputs 0.

Decomposition:
- Shared package (alongside existing defines): ExcCode constants, CP0 register addresses (STATUS=12, CAUSE=13, EPC=14), mem_exc_i bit indices, EXC_VECTOR default.
- One sub-module: exc_int_sync, a 2-flop synchroniser parameterised by width.

Test Plan:
- sys=1, pc=0x100, not delay slot, valid:
  - Cycle N+1: exc_we_o=1, code 0x08, epc 0x100, bd 0, new_pc 0x20.
  - flush_o high for 3 cycles.
- ov=1, pc=0x204, delay slot → epc 0x200, bd 1, code 0x0C.
- Status=0x0000_0401, int_i[0] raised → 2 sync cycles, then with valid instr pc=0x300: code 0x00, epc 0x300. Same stimulus with Status=0x0000_0403 (EXL=1) → no event.
- eret=1, WB mtc0 EPC=0x1234 in the same cycle → new_pc_o=0x1234, eret_o=1.
- ri and bp together, followed by sys during FLUSH → only code 0x0A reported; sys ignored.
- rst_n dropped during FLUSH → flush_o=0 immediately; next sys taken normally after reset release.
